// File: rtl/kf_db_pkg.sv
`default_nettype none
// ============================================================================
// Module      : kf_db_pkg
// Description : Shared sizing and read-engine state encoding for the data bank.
// Revision    : 1.0 - initial release
// ============================================================================
package kf_db_pkg;

    localparam int c_db_w     = 24;
    localparam int c_db_depth = 40;
    localparam int c_db_addrw = 6;

    localparam int c_st_w = 2;
    typedef logic [c_st_w-1:0] state_t;

    localparam state_t c_st_idle  = 2'd0;
    localparam state_t c_st_run   = 2'd1;
    localparam state_t c_st_drain = 2'd2;

endpackage
`default_nettype wire

// File: rtl/db_rd_stage.sv
`default_nettype none
// ============================================================================
// Module      : db_rd_stage
// Description : Output register for a bank reader: load, hold while stalled,
//               clear after the final handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module db_rd_stage
    import kf_db_pkg::*;
#(
    parameter int W = c_db_w
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_load,
    input  logic         i_clear,
    input  logic [W-1:0] i_data_a,
    input  logic [W-1:0] i_data_b,
    input  logic         i_b_vld,
    input  logic         i_last,
    output logic         o_valid,
    output logic [W-1:0] o_data_a,
    output logic [W-1:0] o_data_b,
    output logic         o_b_vld,
    output logic         o_last
);

    logic         r_valid;
    logic [W-1:0] r_data_a;
    logic [W-1:0] r_data_b;
    logic         r_b_vld;
    logic         r_last;

    // Load wins over clear so a reader may refill in the same cycle it drains.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid  <= 1'b0;
            r_data_a <= '0;
            r_data_b <= '0;
            r_b_vld  <= 1'b0;
            r_last   <= 1'b0;
        end else if (i_load) begin
            r_valid  <= 1'b1;
            r_data_a <= i_data_a;
            r_data_b <= i_data_b;
            r_b_vld  <= i_b_vld;
            r_last   <= i_last;
        end else if (i_clear) begin
            r_valid  <= 1'b0;
            r_last   <= 1'b0;
        end
    end

    assign o_valid  = r_valid;
    assign o_data_a = r_data_a;
    assign o_data_b = r_data_b;
    assign o_b_vld  = r_b_vld;
    assign o_last   = r_last;

endmodule
`default_nettype wire

// File: rtl/db_burst_reader.sv
`default_nettype none
// ============================================================================
// Module      : db_burst_reader
// Description : Burst read engine sweeping the data bank's two async read
//               ports and streaming words out on valid/ready.
// Revision    : 1.0 - initial release
// ============================================================================
module db_burst_reader
    import kf_db_pkg::*;
#(
    parameter int W     = c_db_w,
    parameter int DEPTH = c_db_depth,
    parameter int ADDRW = c_db_addrw
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [ADDRW-1:0] cmd_base,
    input  logic [ADDRW:0]   cmd_len,
    input  logic             cmd_pair,
    output logic [ADDRW-1:0] db_raddr_a,
    output logic [ADDRW-1:0] db_raddr_b,
    input  logic [W-1:0]     db_rdata_a,
    input  logic [W-1:0]     db_rdata_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     out_data_a,
    output logic [W-1:0]     out_data_b,
    output logic             out_b_vld,
    output logic             out_last,
    output logic             done,
    output logic             err
);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [ADDRW-1:0] r_base;
    logic [ADDRW:0]   r_beats;
    logic [ADDRW:0]   r_idx;
    logic             r_pair;
    logic             r_odd;
    logic             r_err;
    logic             r_done;

    logic [ADDRW+1:0] w_end;
    logic [ADDRW:0]   w_beats;
    logic [ADDRW-1:0] w_off;
    logic [ADDRW-1:0] w_addr_a;
    logic             w_accept;
    logic             w_illegal;
    logic             w_run;
    logic             w_load;
    logic             w_last;
    logic             w_b_vld;
    logic             w_hs;
    logic             w_clear;

    assign cmd_ready = (r_state == c_st_idle);
    assign w_accept  = cmd_valid & cmd_ready;
    // Extra headroom bits make base+len exact, so no wrapped burst can pass.
    assign w_end     = {2'b00, cmd_base} + {1'b0, cmd_len};
    assign w_illegal = (cmd_len == '0) || (w_end > (ADDRW+2)'(DEPTH));
    assign w_beats   = cmd_pair ? ({1'b0, cmd_len[ADDRW:1]} + {{ADDRW{1'b0}}, cmd_len[0]})
                                : cmd_len;

    assign w_run    = (r_state == c_st_run);
    assign w_hs     = out_valid & out_ready;
    assign w_load   = w_run & (~out_valid | out_ready);
    assign w_clear  = (r_state == c_st_drain) & w_hs;
    assign w_last   = (r_idx == r_beats - (ADDRW+1)'(1));
    assign w_b_vld  = r_pair & ~(w_last & r_odd);
    assign w_off    = r_pair ? {r_idx[ADDRW-2:0], 1'b0} : r_idx[ADDRW-1:0];
    assign w_addr_a = r_base + w_off;

    // Port B mirrors port A on the odd tail beat so it never leaves the burst.
    assign db_raddr_a = w_run ? w_addr_a : '0;
    assign db_raddr_b = (w_run & r_pair) ? (w_b_vld ? w_addr_a + ADDRW'(1) : w_addr_a) : '0;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_idle:  if (w_accept && !w_illegal) w_state_nxt = c_st_run;
            c_st_run:   if (w_load && w_last)       w_state_nxt = c_st_drain;
            c_st_drain: if (w_hs)                   w_state_nxt = c_st_idle;
            default:                                w_state_nxt = c_st_idle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_st_idle;
            r_base  <= '0;
            r_beats <= '0;
            r_idx   <= '0;
            r_pair  <= 1'b0;
            r_odd   <= 1'b0;
            r_err   <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_err   <= w_accept & w_illegal;
            r_done  <= w_clear;
            if (w_accept && !w_illegal) begin
                r_base  <= cmd_base;
                r_pair  <= cmd_pair;
                r_odd   <= cmd_len[0];
                r_beats <= w_beats;
                r_idx   <= '0;
            end else if (w_load) begin
                r_idx   <= r_idx + (ADDRW+1)'(1);
            end
        end
    end

    assign done = r_done;
    assign err  = r_err;

    db_rd_stage #(
        .W (W)
    ) u_rd_stage (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_load   (w_load),
        .i_clear  (w_clear),
        .i_data_a (db_rdata_a),
        .i_data_b (w_b_vld ? db_rdata_b : '0),
        .i_b_vld  (w_b_vld),
        .i_last   (w_last),
        .o_valid  (out_valid),
        .o_data_a (out_data_a),
        .o_data_b (out_data_b),
        .o_b_vld  (out_b_vld),
        .o_last   (out_last)
    );

endmodule
`default_nettype wire

// File: tb/tb_db_burst_reader.sv
`default_nettype none
// ============================================================================
// Module      : tb_db_burst_reader
// Description : Self-checking bench for db_burst_reader with a behavioural
//               bank model and a burst-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_db_burst_reader;

    localparam int W     = 24;
    localparam int DEPTH = 40;
    localparam int ADDRW = 6;

    typedef struct packed {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         bv;
        logic         last;
    } beat_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic             cmd_valid = 1'b0;
    logic             cmd_ready;
    logic [ADDRW-1:0] cmd_base = '0;
    logic [ADDRW:0]   cmd_len = '0;
    logic             cmd_pair = 1'b0;
    logic [ADDRW-1:0] db_raddr_a, db_raddr_b;
    logic [W-1:0]     db_rdata_a, db_rdata_b;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [W-1:0]     out_data_a, out_data_b;
    logic             out_b_vld, out_last, done, err;

    logic [W-1:0]     mem [0:(1<<ADDRW)-1];
    logic             wr_en = 1'b0;
    logic [ADDRW-1:0] wr_addr = '0;
    logic [W-1:0]     wr_data = '0;
    logic             wr_arm = 1'b0;
    logic [ADDRW-1:0] wr_target = '0;
    logic [W-1:0]     wr_value = '0;

    int checks = 0;
    int errors = 0;
    beat_t got[$];
    beat_t exp_q[$];
    int err_cnt, done_cnt, stall_bad, hs_last_cyc, done_cyc, timed_out;
    logic v_e0, v_e1, ready_at_done;

    always #5 clk = ~clk;

    // Bank model: combinational read with write forwarding, write on clock edge.
    assign db_rdata_a = (wr_en && wr_addr == db_raddr_a) ? wr_data : mem[db_raddr_a];
    assign db_rdata_b = (wr_en && wr_addr == db_raddr_b) ? wr_data : mem[db_raddr_b];
    always @(posedge clk) if (wr_en) mem[wr_addr] <= wr_data;

    db_burst_reader #(.W(W), .DEPTH(DEPTH), .ADDRW(ADDRW)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_base(cmd_base),
        .cmd_len(cmd_len), .cmd_pair(cmd_pair),
        .db_raddr_a(db_raddr_a), .db_raddr_b(db_raddr_b),
        .db_rdata_a(db_rdata_a), .db_rdata_b(db_rdata_b),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data_a(out_data_a), .out_data_b(out_data_b),
        .out_b_vld(out_b_vld), .out_last(out_last),
        .done(done), .err(err)
    );

    // Reference: walk the burst in word steps of 1 or 2 straight from the bank contents.
    task automatic build_exp(input int base, input int len, input logic pair);
        beat_t bt;
        int step;
        step = pair ? 2 : 1;
        exp_q.delete();
        for (int k = 0; k < len; k += step) begin
            bt.a    = mem[base + k];
            bt.bv   = pair && (k + 1 < len);
            bt.b    = bt.bv ? mem[base + k + 1] : '0;
            bt.last = (k + step >= len);
            exp_q.push_back(bt);
        end
    endtask

    task automatic do_burst(input int base, input int len, input logic pair,
                            input int mode, input int max_cyc);
        logic [3+2*W+2*ADDRW-1:0] snap, cur;
        logic stalled;
        beat_t bt;
        got.delete();
        err_cnt = 0; done_cnt = 0; stall_bad = 0; hs_last_cyc = -1; done_cyc = -2;
        timed_out = 1; ready_at_done = 1'b0; stalled = 1'b0; snap = '0;
        @(negedge clk);
        out_ready = 1'b0;
        cmd_valid = 1'b1; cmd_base = ADDRW'(base); cmd_len = (ADDRW+1)'(len); cmd_pair = pair;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0; cmd_base = ADDRW'($urandom); cmd_len = (ADDRW+1)'($urandom); cmd_pair = 1'($urandom);
        v_e0 = out_valid;
        if (err) err_cnt++;
        for (int cyc = 1; cyc <= max_cyc; cyc++) begin
            cur = {out_valid, out_data_a, out_data_b, out_b_vld, out_last, db_raddr_a, db_raddr_b};
            if (stalled && cur !== snap) stall_bad++;
            case (mode)
                0:       out_ready = 1'b1;
                1:       out_ready = ((cyc % 3) == 1);
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            if (wr_arm && db_raddr_a == wr_target && out_ready) begin
                wr_en = 1'b1; wr_addr = wr_target; wr_data = wr_value; wr_arm = 1'b0;
            end
            if (out_valid && out_ready) begin
                bt = '{a: out_data_a, b: out_data_b, bv: out_b_vld, last: out_last};
                got.push_back(bt);
                if (out_last) hs_last_cyc = cyc;
            end
            stalled = out_valid && !out_ready;
            snap = cur;
            @(posedge clk);
            @(negedge clk);
            wr_en = 1'b0;
            if (cyc == 1) v_e1 = out_valid;
            if (err) err_cnt++;
            if (done) begin
                done_cnt++; done_cyc = cyc; ready_at_done = cmd_ready; timed_out = 0;
                break;
            end
        end
        out_ready = 1'b0;
    endtask

    task automatic test_reset;
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({out_valid, out_data_a, out_data_b, out_b_vld, out_last, done, err, db_raddr_a, db_raddr_b} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got v=%b a=%h b=%h bv=%b l=%b d=%b e=%b ra=%0d rb=%0d need all 0",
                     out_valid, out_data_a, out_data_b, out_b_vld, out_last, done, err, db_raddr_a, db_raddr_b);
        end
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++; $display("FAIL reset_cmd_ready got %b need 1", cmd_ready);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_single;
        build_exp(4, 3, 1'b0);
        do_burst(4, 3, 1'b0, 0, 100);
        checks++;
        if (timed_out != 0 || done_cnt != 1 || err_cnt != 0 || got.size() != exp_q.size() ||
            v_e0 !== 1'b0 || v_e1 !== 1'b1 || done_cyc != hs_last_cyc || ready_at_done !== 1'b1) begin
            errors++;
            $display("FAIL single_status got to=%0d done=%0d err=%0d beats=%0d v0=%b v1=%b dcyc=%0d lcyc=%0d rdy=%b need 0 1 0 %0d 0 1 equal 1",
                     timed_out, done_cnt, err_cnt, got.size(), v_e0, v_e1, done_cyc, hs_last_cyc, ready_at_done, exp_q.size());
        end
        for (int k = 0; k < exp_q.size() && k < got.size(); k++) begin
            checks++;
            if (got[k] !== exp_q[k]) begin
                errors++; $display("FAIL single_beat%0d got %h need %h", k, got[k], exp_q[k]);
            end
        end
    endtask

    task automatic test_pair;
        build_exp(10, 5, 1'b1);
        do_burst(10, 5, 1'b1, 0, 100);
        checks++;
        if (timed_out != 0 || done_cnt != 1 || err_cnt != 0 || got.size() != 3 ||
            v_e0 !== 1'b0 || v_e1 !== 1'b1 || done_cyc != hs_last_cyc) begin
            errors++;
            $display("FAIL pair_status got to=%0d done=%0d err=%0d beats=%0d v0=%b v1=%b dcyc=%0d lcyc=%0d need 0 1 0 3 0 1 equal",
                     timed_out, done_cnt, err_cnt, got.size(), v_e0, v_e1, done_cyc, hs_last_cyc);
        end
        for (int k = 0; k < exp_q.size() && k < got.size(); k++) begin
            checks++;
            if (got[k] !== exp_q[k]) begin
                errors++; $display("FAIL pair_beat%0d got %h need %h", k, got[k], exp_q[k]);
            end
        end
    endtask

    task automatic test_backpressure;
        build_exp(0, 4, 1'b0);
        do_burst(0, 4, 1'b0, 1, 100);
        checks++;
        if (timed_out != 0 || done_cnt != 1 || err_cnt != 0 || stall_bad != 0 ||
            got.size() != 4 || done_cyc != hs_last_cyc) begin
            errors++;
            $display("FAIL backpressure_status got to=%0d done=%0d err=%0d stall=%0d beats=%0d dcyc=%0d lcyc=%0d need 0 1 0 0 4 equal",
                     timed_out, done_cnt, err_cnt, stall_bad, got.size(), done_cyc, hs_last_cyc);
        end
        for (int k = 0; k < exp_q.size() && k < got.size(); k++) begin
            checks++;
            if (got[k] !== exp_q[k]) begin
                errors++; $display("FAIL backpressure_beat%0d got %h need %h", k, got[k], exp_q[k]);
            end
        end
    endtask

    task automatic test_illegal;
        int bases[3];
        int lens[3];
        bases = '{38, int'($urandom_range(0, DEPTH-1)), DEPTH-1};
        lens  = '{3, 0, 2};
        for (int t = 0; t < 3; t++) begin
            do_burst(bases[t], lens[t], 1'($urandom_range(0, 1)), 0, 8);
            checks++;
            if (err_cnt != 1 || got.size() != 0 || done_cnt != 0 || cmd_ready !== 1'b1) begin
                errors++;
                $display("FAIL illegal%0d got err=%0d beats=%0d done=%0d rdy=%b need 1 0 0 1",
                         t, err_cnt, got.size(), done_cnt, cmd_ready);
            end
        end
        for (int p = 0; p < 2; p++) begin
            build_exp(DEPTH-1, 1, 1'(p));
            do_burst(DEPTH-1, 1, 1'(p), 0, 20);
            checks++;
            if (timed_out != 0 || err_cnt != 0 || got.size() != 1 || done_cnt != 1 ||
                (got.size() == 1 && got[0] !== exp_q[0])) begin
                errors++;
                $display("FAIL last_word_pair%0d got to=%0d err=%0d beats=%0d first=%h need 0 0 1 %h",
                         p, timed_out, err_cnt, got.size(), (got.size() > 0) ? got[0] : '0, exp_q[0]);
            end
        end
    endtask

    task automatic test_full_depth;
        for (int p = 0; p < 2; p++) begin
            build_exp(0, DEPTH, 1'(p));
            do_burst(0, DEPTH, 1'(p), 2, 1000);
            checks++;
            if (timed_out != 0 || done_cnt != 1 || err_cnt != 0 || stall_bad != 0 ||
                got.size() != exp_q.size() || done_cyc != hs_last_cyc) begin
                errors++;
                $display("FAIL full_depth%0d_status got to=%0d done=%0d err=%0d stall=%0d beats=%0d need 0 1 0 0 %0d",
                         p, timed_out, done_cnt, err_cnt, stall_bad, got.size(), exp_q.size());
            end
            for (int k = 0; k < exp_q.size() && k < got.size(); k++) begin
                checks++;
                if (got[k] !== exp_q[k]) begin
                    errors++; $display("FAIL full_depth%0d_beat%0d got %h need %h", p, k, got[k], exp_q[k]);
                end
            end
        end
    endtask

    task automatic test_reset_mid;
        logic was_valid;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_base = '0; cmd_len = 7'd8; cmd_pair = 1'b0;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0; out_ready = 1'b1;
        repeat (2) begin
            @(posedge clk);
            @(negedge clk);
        end
        was_valid = out_valid;
        rst_n = 1'b0;
        #1;
        checks++;
        if (was_valid !== 1'b1 || {out_valid, done, err, db_raddr_a, db_raddr_b} !== '0) begin
            errors++;
            $display("FAIL reset_mid got pre_v=%b v=%b d=%b e=%b ra=%0d rb=%0d need 1 0 0 0 0 0",
                     was_valid, out_valid, done, err, db_raddr_a, db_raddr_b);
        end
        @(negedge clk);
        rst_n = 1'b1; out_ready = 1'b0;
        #1;
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++; $display("FAIL reset_mid_ready got %b need 1", cmd_ready);
        end
        build_exp(20, 7, 1'b1);
        do_burst(20, 7, 1'b1, 2, 200);
        checks++;
        if (timed_out != 0 || done_cnt != 1 || err_cnt != 0 || stall_bad != 0 || got.size() != exp_q.size()) begin
            errors++;
            $display("FAIL reset_mid_rerun got to=%0d done=%0d err=%0d stall=%0d beats=%0d need 0 1 0 0 %0d",
                     timed_out, done_cnt, err_cnt, stall_bad, got.size(), exp_q.size());
        end
        for (int k = 0; k < exp_q.size() && k < got.size(); k++) begin
            checks++;
            if (got[k] !== exp_q[k]) begin
                errors++; $display("FAIL reset_mid_beat%0d got %h need %h", k, got[k], exp_q[k]);
            end
        end
    endtask

    task automatic test_write_during_read;
        build_exp(4, 5, 1'b0);
        exp_q[2].a = 24'hABCDEF;
        wr_arm = 1'b1; wr_target = 6'd6; wr_value = 24'hABCDEF;
        do_burst(4, 5, 1'b0, 0, 100);
        checks++;
        if (timed_out != 0 || done_cnt != 1 || wr_arm !== 1'b0 || got.size() != 5) begin
            errors++;
            $display("FAIL wdr_status got to=%0d done=%0d armed=%b beats=%0d need 0 1 0 5",
                     timed_out, done_cnt, wr_arm, got.size());
        end
        for (int k = 0; k < exp_q.size() && k < got.size(); k++) begin
            checks++;
            if (got[k] !== exp_q[k]) begin
                errors++; $display("FAIL wdr_beat%0d got %h need %h", k, got[k], exp_q[k]);
            end
        end
    endtask

    task automatic test_random;
        int len, base;
        logic pair;
        for (int n = 0; n < 8; n++) begin
            len  = $urandom_range(1, DEPTH);
            base = $urandom_range(0, DEPTH - len);
            pair = 1'($urandom_range(0, 1));
            build_exp(base, len, pair);
            do_burst(base, len, pair, 2, 1000);
            checks++;
            if (timed_out != 0 || done_cnt != 1 || err_cnt != 0 || stall_bad != 0 ||
                got.size() != exp_q.size() || v_e1 !== 1'b1 || done_cyc != hs_last_cyc) begin
                errors++;
                $display("FAIL rand%0d_status base=%0d len=%0d pair=%b got to=%0d done=%0d err=%0d stall=%0d beats=%0d v1=%b need 0 1 0 0 %0d 1",
                         n, base, len, pair, timed_out, done_cnt, err_cnt, stall_bad, got.size(), v_e1, exp_q.size());
            end
            for (int k = 0; k < exp_q.size() && k < got.size(); k++) begin
                checks++;
                if (got[k] !== exp_q[k]) begin
                    errors++; $display("FAIL rand%0d_beat%0d got %h need %h", n, k, got[k], exp_q[k]);
                end
            end
        end
    endtask

    initial begin
        for (int k = 0; k < (1 << ADDRW); k++) mem[k] = 24'h100000 + W'(k);
        test_reset();
        test_single();
        test_pair();
        test_backpressure();
        test_illegal();
        test_full_depth();
        test_reset_mid();
        test_write_during_read();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/db_burst_reader.md
Name: db_burst_reader

Overview:
- Read-side engine for the flop-based data bank's two asynchronous read ports.
- Accepts a burst command (base address, word count, single/pair mode) and sweeps the bank's read addresses.
- Registers the returned words and streams them out on a valid/ready interface with full backpressure.
- Sits between the data bank and the host/debug unload path, which dumps the state vector and covariance after each filter iteration.

Parameters:
- W, 24, data word width; must match the data bank.
- DEPTH, 40, number of data bank entries.
- ADDRW, 6, address width; 2**ADDRW >= DEPTH.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cmd_valid  in  1  burst command valid.
- cmd_ready  out  1  engine can accept a command.
- cmd_base  in  ADDRW  first word address.
- cmd_len  in  ADDRW+1  words to read, 1..DEPTH.
- cmd_pair  in  1  1 = two words per beat (ports A and B); 0 = one word per beat (port A).
- db_raddr_a  out  ADDRW  data bank read address A.
- db_raddr_b  out  ADDRW  data bank read address B.
- db_rdata_a  in  W  data bank read data A (combinational from db_raddr_a).
- db_rdata_b  in  W  data bank read data B.
- out_valid  out  1  output beat valid.
- out_ready  in  1  consumer accepts beat.
- out_data_a  out  W  lower-address word.
- out_data_b  out  W  upper word (pair mode); 0 otherwise.
- out_b_vld  out  1  out_data_b carries a real word.
- out_last  out  1  final beat of the burst.
- done  out  1  one-cycle pulse after the last beat handshake.
- err  out  1  one-cycle pulse: command rejected.

Behaviour:
- Reset (async assert, sync-released usage):
  - State IDLE; all outputs 0 except cmd_ready = 1.
  - db_raddr_a and db_raddr_b = 0.
  - In-flight burst is abandoned; out_valid drops immediately.
- States:
  - IDLE: cmd_ready = 1.
  - RUN: addresses are issued.
  - DRAIN: last beat is held, waiting for out_ready.
- Command acceptance (cmd_valid & cmd_ready at edge E0):
  - Illegal if cmd_len == 0 or cmd_base + cmd_len > DEPTH. Compute the sum in ADDRW+2 bits; no address wrap-around is ever permitted.
  - Illegal command: err = 1 in the cycle after E0; stay IDLE; no beats; no done.
  - Legal command: latch base/len/pair.
    - beats = len (single mode) or ceil(len/2) (pair mode).
    - Go to RUN; beat index i = 0.
- RUN addressing:
  - Single mode: db_raddr_a = base + i; db_raddr_b = 0.
  - Pair mode: db_raddr_a = base + 2i; db_raddr_b = base + 2i + 1.
  - For the odd final pair beat, db_raddr_b = db_raddr_a and out_b_vld = 0.
- Load rule:
  - Output register loads when in RUN and (!out_valid | out_ready).
  - On load: out_valid = 1; out_data_a = db_rdata_a.
  - out_data_b = db_rdata_b if out_b_vld, else 0.
  - out_last = (i == beats-1); then i increments.
- Stall: when out_valid & !out_ready, all out_* and db_raddr_* hold stable.
- Stability: data are those sampled at the load edge. A bank write to a read address in that cycle is observed through the bank's forwarding.
- Latency:
  - Command accepted at E0; first beat valid after E1.
  - Throughput 1 beat/cycle when out_ready is held high.
- State transitions:
  - Loading the last beat moves RUN -> DRAIN.
  - In DRAIN, the out_last handshake clears out_valid, pulses done next cycle, and returns to IDLE.
  - cmd_ready = 0 in RUN and DRAIN. A new command is accepted no earlier than the cycle done is high.
- cmd_len = 1 in pair mode: one beat with out_b_vld = 0 and out_last = 1.
- Full-depth bursts (base = 0, len = DEPTH) are legal. base = DEPTH-1, len = 1 is legal; len = 2 is illegal.
- out_valid never deasserts without a handshake, except on reset.

Decomposition:
- Shared package kf_db_pkg: W, DEPTH, ADDRW defaults (shared with the data bank and mem_reg); state enum IDLE/RUN/DRAIN.
- One natural sub-module, db_rd_stage: the output register with load/hold/clear logic, reusable for other bank readers.
- FSM, counters and the legality check stay in the top module.

Test Plan:
- Bank preloaded with mem[k] = 0x100000 + k; single mode, base 4, len 3, out_ready = 1:
  - Beats are 0x100004, 0x100005, 0x100006.
  - out_last on the 3rd beat; done one cycle later.
  - First out_valid 2 edges after acceptance.
- Pair mode, base 10, len 5:
  - Beats (0x10000A, 0x10000B), (0x10000C, 0x10000D), then (0x10000E, 0) with out_b_vld = 0 and out_last = 1.
- Backpressure: single mode, base 0, len 4, out_ready toggling 1,0,0,1,...:
  - Data and addresses hold during stalls; exactly 4 beats in order, no duplicates or drops.
- Illegal commands:
  - base 38, len 3 (DEPTH 40) -> err pulse, no out_valid, cmd_ready stays 1.
  - len 0 -> err pulse.
  - base 0, len 40 -> accepted, 40 beats.
- Reset mid-burst: assert rst_n = 0 during beat 2 of an 8-beat burst:
  - out_valid, done, err and addresses go to 0 immediately; cmd_ready = 1 after release.
  - A new burst then runs correctly.
- Write during read: a bank write of 0xABCDEF to address 6 in the load cycle of the beat reading address 6 -> that beat carries 0xABCDEF.
